// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy group: movement/facing codes, draw FSM
// state encoding and the facing -> sprite-sheet row mapping.
package enemy_pkg;

   // Direction and facing share one 3-bit code space.
   typedef enum logic [2:0] {
      NO_ACTION = 3'b000,
      ATTACK    = 3'b001,
      UP        = 3'b010,
      DOWN      = 3'b011,
      LEFT      = 3'b100,
      RIGHT     = 3'b101
   } dir_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_PIX   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } draw_state_t;

   // Sprite sheet holds four views stacked: DOWN, LEFT, UP, RIGHT.
   function automatic logic [1:0] facing_idx(input logic [2:0] f);
      logic [1:0] idx;
      idx = 2'd0;
      case (f)
         DOWN:    idx = 2'd0;
         LEFT:    idx = 2'd1;
         UP:      idx = 2'd2;
         RIGHT:   idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/enemy_group_if.sv
// Bundle of control strobes, enemy state outputs and the sprite/VGA path.
//
// Control strobes init/gen_move/apply_move are single-cycle pulses sampled on
// the rising clock edge; draw is a level held high until draw_done pulses for
// one cycle, and dropping draw early aborts the pass. sprite_colour must be the
// ROM word for the sprite_addr presented on the previous cycle; x_draw/y_draw
// and VGA_write line up with it.
interface enemy_group_if #(
   parameter int N  = 4,
   parameter int AW = 10
);
   logic             init;
   logic             gen_move;
   logic             apply_move;
   logic             draw;
   logic [N-1:0]     collision;
   logic [N-1:0]     hit;
   logic [8:0]       link_x_pos;
   logic [7:0]       link_y_pos;
   logic [9*N-1:0]   x_pos;
   logic [8*N-1:0]   y_pos;
   logic [3*N-1:0]   facing;
   logic [N-1:0]     alive;
   logic [AW-1:0]    sprite_addr;
   logic [5:0]       sprite_colour;
   logic [8:0]       x_draw;
   logic [7:0]       y_draw;
   logic             VGA_write;
   logic             draw_done;
   logic             all_dead;
   logic [2:0]       draw_state;

   modport slave (
      input  init, gen_move, apply_move, draw, collision, hit,
             link_x_pos, link_y_pos, sprite_colour,
      output x_pos, y_pos, facing, alive, sprite_addr, x_draw, y_draw,
             VGA_write, draw_done, all_dead, draw_state
   );

   modport master (
      output init, gen_move, apply_move, draw, collision, hit,
             link_x_pos, link_y_pos, sprite_colour,
      input  x_pos, y_pos, facing, alive, sprite_addr, x_draw, y_draw,
             VGA_write, draw_done, all_dead, draw_state
   );
endinterface

// File: rtl/random_number_generator.sv
// Free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1).
module random_number_generator #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [15:0] rnd_o
);
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Advance every clock; seed must be non-zero to avoid the lock-up state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign rnd_o = lfsr_q;
endmodule

// File: rtl/enemy_group.sv
// NUM_ENEMIES enemies sharing one set of control strobes, plus a draw engine
// that serialises every live enemy's sprite into one pixel stream.
module enemy_group
   import enemy_pkg::*;
#(
   parameter int          NUM_ENEMIES = 4,
   parameter int          SPRITE_W    = 16,
   parameter int          SPRITE_H    = 16,
   parameter int          STEP        = 1,
   parameter int          MAX_HP      = 3,
   parameter int          MODE        = 1,
   parameter int          SPAWN_X0    = 210,
   parameter int          SPAWN_DX    = 20,
   parameter int          SPAWN_Y     = 96,
   parameter int          X_MAX       = 320,
   parameter int          Y_MAX       = 240,
   parameter logic [5:0]  TRANSPARENT = 6'b111111,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic          clock,
   input logic          reset,
   enemy_group_if.slave bus
);
   localparam int         COLW   = $clog2(SPRITE_W);
   localparam int         CW     = $clog2(SPRITE_W * SPRITE_H);
   localparam int         IW     = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
   localparam logic [8:0] X_LIM  = 9'(X_MAX - SPRITE_W);
   localparam logic [7:0] Y_LIM  = 8'(Y_MAX - SPRITE_H);
   localparam logic [8:0] STEP_X = 9'(STEP);
   localparam logic [7:0] STEP_Y = 8'(STEP);

   logic [15:0]              rnd;
   logic [9*NUM_ENEMIES-1:0] x_pos_w;
   logic [8*NUM_ENEMIES-1:0] y_pos_w;
   logic [3*NUM_ENEMIES-1:0] facing_w;
   logic [NUM_ENEMIES-1:0]   alive_w;

   random_number_generator #(.SEED(LFSR_SEED)) u_rng (
      .clk_i  (clock),
      .rst_ni (reset),
      .rnd_o  (rnd)
   );

   for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
      localparam logic [8:0] SPAWN_XI = 9'(SPAWN_X0 - i * SPAWN_DX);
      localparam logic [7:0] SPAWN_YI = 8'(SPAWN_Y);
      localparam logic [3:0] HP_INIT  = 4'(MAX_HP);

      logic [8:0] x_q;
      logic [7:0] y_q;
      logic [2:0] facing_q;
      logic [2:0] dir_q;
      logic [3:0] hp_q;
      logic       alive_q;
      logic [3:0] r;
      logic [2:0] wander;
      logic [2:0] dir_d;
      logic [9:0] x_sum;
      logic [8:0] y_sum;
      logic [8:0] x_mv;
      logic [7:0] y_mv;

      assign r = rnd[4*(i%4) +: 4];

      // Pick this enemy's next direction: chase Link (y before x) or wander.
      always_comb begin
         wander = UP;
         case (r[3:2])
            2'b01:   wander = DOWN;
            2'b10:   wander = LEFT;
            2'b11:   wander = RIGHT;
            default: wander = UP;
         endcase
         dir_d = NO_ACTION;
         if (alive_q) begin
            if (MODE == 0 || r[1:0] == 2'b11)   dir_d = wander;
            else if (bus.link_y_pos < y_q)      dir_d = UP;
            else if (bus.link_y_pos > y_q)      dir_d = DOWN;
            else if (bus.link_x_pos < x_q)      dir_d = LEFT;
            else if (bus.link_x_pos > x_q)      dir_d = RIGHT;
            else                                dir_d = NO_ACTION;
         end
      end

      // Candidate position one STEP along dir_q, clamped to the playfield.
      always_comb begin
         x_sum = {1'b0, x_q} + {1'b0, STEP_X};
         y_sum = {1'b0, y_q} + {1'b0, STEP_Y};
         x_mv  = x_q;
         y_mv  = y_q;
         case (dir_q)
            UP:      y_mv = (y_q < STEP_Y) ? 8'd0 : y_q - STEP_Y;
            DOWN:    y_mv = (y_sum > {1'b0, Y_LIM}) ? Y_LIM : y_sum[7:0];
            LEFT:    x_mv = (x_q < STEP_X) ? 9'd0 : x_q - STEP_X;
            RIGHT:   x_mv = (x_sum > {1'b0, X_LIM}) ? X_LIM : x_sum[8:0];
            default: ;
         endcase
      end

      // Per-enemy state: spawn, latch direction, then move/face/take hits.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            x_q      <= '0;
            y_q      <= '0;
            facing_q <= DOWN;
            dir_q    <= NO_ACTION;
            hp_q     <= '0;
            alive_q  <= 1'b0;
         end else if (bus.init) begin
            x_q      <= SPAWN_XI;
            y_q      <= SPAWN_YI;
            facing_q <= DOWN;
            dir_q    <= NO_ACTION;
            hp_q     <= HP_INIT;
            alive_q  <= 1'b1;
         end else if (bus.gen_move) begin
            dir_q <= dir_d;
         end else if (bus.apply_move && alive_q) begin
            if (dir_q != NO_ACTION && dir_q != ATTACK) facing_q <= dir_q;
            if (!bus.collision[i]) begin
               x_q <= x_mv;
               y_q <= y_mv;
            end
            if (bus.hit[i]) begin
               hp_q <= hp_q - 4'd1;
               if (hp_q == 4'd1) alive_q <= 1'b0;
            end
         end
      end

      assign x_pos_w[9*i +: 9]  = x_q;
      assign y_pos_w[8*i +: 8]  = y_q;
      assign facing_w[3*i +: 3] = facing_q;
      assign alive_w[i]         = alive_q;
   end

   // ---------------- draw engine ----------------
   draw_state_t   state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic [8:0]    x_draw_q;
   logic [7:0]    y_draw_q;
   logic [8:0]    cur_x;
   logic [7:0]    cur_y;
   logic [2:0]    cur_f;
   logic          last_idx;

   assign cur_x    = x_pos_w[9*int'(idx_q) +: 9];
   assign cur_y    = y_pos_w[8*int'(idx_q) +: 8];
   assign cur_f    = facing_w[3*int'(idx_q) +: 3];
   assign last_idx = (idx_q == IW'(NUM_ENEMIES - 1));

   // Next-state: walk enemies, stream W*H addresses per live one, then flush.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      if (bus.init) begin
         state_d = S_IDLE;
      end else if (!(bus.gen_move || bus.apply_move)) begin
         case (state_q)
            S_IDLE: if (bus.draw) begin
               state_d = S_SCAN;
               idx_d   = '0;
            end
            S_SCAN: begin
               if (!bus.draw)            state_d = S_IDLE;
               else if (alive_w[idx_q]) begin
                  state_d = S_PIX;
                  cnt_d   = '0;
               end
               else if (last_idx)        state_d = S_FLUSH;
               else                      idx_d   = idx_q + IW'(1);
            end
            S_PIX: begin
               if (!bus.draw) state_d = S_IDLE;
               else begin
                  valid_d = 1'b1;
                  cnt_d   = cnt_q + CW'(1);
                  if (&cnt_q) begin
                     if (last_idx) state_d = S_FLUSH;
                     else begin
                        state_d = S_SCAN;
                        idx_d   = idx_q + IW'(1);
                     end
                  end
               end
            end
            S_FLUSH: state_d = bus.draw ? S_DONE : S_IDLE;
            S_DONE:  if (!bus.draw) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      done_d = (state_d == S_DONE) && (state_q != S_DONE);
   end

   // Draw registers; pixel coordinates ride one cycle behind the address.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         x_draw_q <= '0;
         y_draw_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         if (valid_d) begin
            x_draw_q <= cur_x + 9'(cnt_q[COLW-1:0]);
            y_draw_q <= cur_y + 8'(cnt_q[CW-1:COLW]);
         end
      end
   end

   assign bus.sprite_addr = valid_d ? {facing_idx(cur_f), cnt_q} : '0;
   assign bus.x_draw      = x_draw_q;
   assign bus.y_draw      = y_draw_q;
   assign bus.VGA_write   = valid_q && (bus.sprite_colour != TRANSPARENT);
   assign bus.draw_done   = done_q;
   assign bus.draw_state  = state_q;
   assign bus.x_pos       = x_pos_w;
   assign bus.y_pos       = y_pos_w;
   assign bus.facing      = facing_w;
   assign bus.alive       = alive_w;
   assign bus.all_dead    = &(~alive_w);
endmodule

// File: tb/tb_enemy_group.sv
// Directed bench for enemy_group: spawn, chase, clamping, hits and the
// serialised sprite draw against an expected-pixel queue.
module tb_enemy_group;
   import enemy_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;

   enemy_group_if #(.N(4), .AW(10)) bus ();

   enemy_group dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Sprite ROM model: column 0 transparent, other columns opaque.
   always @(posedge clock) begin
      if (bus.sprite_addr[3:0] == 4'd0) bus.sprite_colour <= 6'b111111;
      else                              bus.sprite_colour <= {2'b01, bus.sprite_addr[3:0]};
   end

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          n_pix  = 0;
   logic [16:0] exp_q[$];
   int          ex[4];
   int          ey[4];
   logic [3:0]  alive_exp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every written pixel must be the next expected coordinate.
   always @(negedge clock) begin
      if (bus.VGA_write === 1'b1) begin
         n_pix++;
         if (exp_q.size() == 0) check("pix_extra", 64'd1, 64'd0);
         else check("pix_xy", {bus.x_draw, bus.y_draw}, exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_init();
      bus.init = 1'b1;
      tick();
      bus.init = 1'b0;
      for (int e = 0; e < 4; e++) begin
         ex[e] = 210 - 20 * e;
         ey[e] = 96;
      end
      alive_exp = 4'b1111;
   endtask

   task automatic gen_apply(input logic [3:0] coll, input logic [3:0] hits);
      bus.gen_move = 1'b1;
      tick();
      bus.gen_move   = 1'b0;
      bus.apply_move = 1'b1;
      bus.collision  = coll;
      bus.hit        = hits;
      tick();
      bus.apply_move = 1'b0;
      bus.collision  = '0;
      bus.hit        = '0;
   endtask

   task automatic apply_only(input logic [3:0] coll, input logic [3:0] hits);
      bus.apply_move = 1'b1;
      bus.collision  = coll;
      bus.hit        = hits;
      tick();
      bus.apply_move = 1'b0;
      bus.collision  = '0;
      bus.hit        = '0;
   endtask

   task automatic push_expected();
      for (int e = 0; e < 4; e++)
         if (alive_exp[e])
            for (int r = 0; r < 16; r++)
               for (int c = 1; c < 16; c++)
                  exp_q.push_back({9'(ex[e] + c), 8'(ey[e] + r)});
   endtask

   task automatic run_draw(input int lat, input int pix);
      int cyc;
      bit seen;
      push_expected();
      n_pix    = 0;
      bus.draw = 1'b1;
      cyc      = 0;
      seen     = 1'b0;
      while (!seen && cyc < 3000) begin
         tick();
         cyc++;
         seen = (bus.draw_done === 1'b1);
      end
      check("draw_latency", 64'(cyc), 64'(lat));
      tick();
      check("done_one_cycle", bus.draw_done, 64'd0);
      check("hold_in_done", bus.draw_state, 64'(S_DONE));
      bus.draw = 1'b0;
      tick();
      check("idle_after_done", bus.draw_state, 64'(S_IDLE));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("pixel_count", 64'(n_pix), 64'(pix));
   endtask

   initial begin
      bit late_done;
      bus.init = 1'b0; bus.gen_move = 1'b0; bus.apply_move = 1'b0; bus.draw = 1'b0;
      bus.collision = '0; bus.hit = '0; bus.link_x_pos = '0; bus.link_y_pos = '0;
      alive_exp = '0;
      repeat (3) tick();

      // Reset state
      check("rst_x", bus.x_pos, 64'd0);
      check("rst_y", bus.y_pos, 64'd0);
      check("rst_facing", bus.facing, 64'(12'b011_011_011_011));
      check("rst_alive", bus.alive, 64'd0);
      check("rst_all_dead", bus.all_dead, 64'd1);
      check("rst_vga", bus.VGA_write, 64'd0);
      check("rst_done", bus.draw_done, 64'd0);
      check("rst_addr", bus.sprite_addr, 64'd0);
      check("rst_xdraw", bus.x_draw, 64'd0);
      check("rst_state", bus.draw_state, 64'(S_IDLE));

      reset = 1'b1;
      tick();
      do_init();
      check("spawn_x", bus.x_pos, 64'({9'd150, 9'd170, 9'd190, 9'd210}));
      check("spawn_y", bus.y_pos, 64'({4{8'd96}}));
      check("spawn_alive", bus.alive, 64'(4'b1111));
      check("spawn_all_dead", bus.all_dead, 64'd0);
      check("spawn_facing", bus.facing, 64'(12'b011_011_011_011));

      // Reset asserted in the middle of a draw
      push_expected();
      bus.draw = 1'b1;
      repeat (50) tick();
      #2 reset = 1'b0;
      #1;
      check("midrst_vga", bus.VGA_write, 64'd0);
      check("midrst_done", bus.draw_done, 64'd0);
      check("midrst_alive", bus.alive, 64'd0);
      check("midrst_all_dead", bus.all_dead, 64'd1);
      check("midrst_state", bus.draw_state, 64'(S_IDLE));
      bus.draw = 1'b0;
      exp_q.delete();
      tick();
      reset = 1'b1;
      tick();
      do_init();
      check("reinit_x0", bus.x_pos[8:0], 64'd210);
      check("reinit_x1", bus.x_pos[17:9], 64'd190);
      check("reinit_y0", bus.y_pos[7:0], 64'd96);
      check("reinit_alive", bus.alive, 64'(4'b1111));

      // Chase with wander disabled
      force dut.rnd = 16'h0000;
      bus.link_x_pos = 9'd100;
      bus.link_y_pos = 8'd50;
      gen_apply(4'b0000, 4'b0000);
      check("chase_y0", bus.y_pos[7:0], 64'd95);
      check("chase_y1", bus.y_pos[15:8], 64'd95);
      check("chase_x0", bus.x_pos[8:0], 64'd210);
      check("chase_facing", bus.facing, 64'(12'b010_010_010_010));

      do_init();
      gen_apply(4'b0001, 4'b0000);
      check("blocked_y0", bus.y_pos[7:0], 64'd96);
      check("blocked_face0", bus.facing[2:0], 64'(UP));
      check("unblocked_y1", bus.y_pos[15:8], 64'd95);

      do_init();
      bus.link_x_pos = 9'd250;
      bus.link_y_pos = 8'd96;
      gen_apply(4'b0000, 4'b0000);
      check("right_x0", bus.x_pos[8:0], 64'd211);
      check("right_x3", bus.x_pos[35:27], 64'd151);
      check("right_face0", bus.facing[2:0], 64'(RIGHT));
      check("right_y0", bus.y_pos[7:0], 64'd96);

      bus.link_x_pos = 9'd211;
      gen_apply(4'b0000, 4'b0000);
      check("aligned_x0", bus.x_pos[8:0], 64'd211);
      check("aligned_face0", bus.facing[2:0], 64'(RIGHT));
      check("aligned_x1", bus.x_pos[17:9], 64'd192);

      bus.link_x_pos = 9'd0;
      gen_apply(4'b0000, 4'b0000);
      check("left_x0", bus.x_pos[8:0], 64'd210);
      check("left_face0", bus.facing[2:0], 64'(LEFT));

      // Clamp at the right and bottom edges
      do_init();
      bus.link_x_pos = 9'd511;
      bus.link_y_pos = 8'd96;
      for (int k = 0; k < 100; k++) gen_apply(4'b0000, 4'b0000);
      check("clamp_x0", bus.x_pos[8:0], 64'd304);
      check("clamp_x3", bus.x_pos[35:27], 64'd250);

      do_init();
      bus.link_x_pos = 9'd0;
      bus.link_y_pos = 8'd255;
      for (int k = 0; k < 140; k++) gen_apply(4'b0000, 4'b0000);
      check("clamp_y0", bus.y_pos[7:0], 64'd224);
      check("clamp_y3", bus.y_pos[31:24], 64'd224);
      check("clamp_y_x0", bus.x_pos[8:0], 64'd210);

      // Hits and death
      do_init();
      bus.link_x_pos = 9'd100;
      bus.link_y_pos = 8'd50;
      apply_only(4'b0000, 4'b0100);
      check("hit1_alive", bus.alive, 64'(4'b1111));
      apply_only(4'b0000, 4'b0100);
      check("hit2_alive", bus.alive, 64'(4'b1111));
      apply_only(4'b0000, 4'b0100);
      check("hit3_alive", bus.alive, 64'(4'b1011));
      check("hit3_all_dead", bus.all_dead, 64'd0);
      alive_exp = 4'b1011;
      gen_apply(4'b0000, 4'b0000);
      check("dead_frozen_y2", bus.y_pos[23:16], 64'd96);
      check("dead_frozen_x2", bus.x_pos[26:18], 64'd170);
      check("live_moved_y0", bus.y_pos[7:0], 64'd95);
      ey[0] = 95; ey[1] = 95; ey[3] = 95;
      for (int k = 0; k < 3; k++) apply_only(4'b1111, 4'b1100);
      check("hit_coll_alive", bus.alive, 64'(4'b0011));
      check("hit_coll_y0", bus.y_pos[7:0], 64'd95);
      check("hit_coll_all_dead", bus.all_dead, 64'd0);
      alive_exp = 4'b0011;

      // Draw with two live enemies: 4 + 2*256 + 2 cycles
      run_draw(518, 480);

      // Abort mid-draw, then redraw from the start
      push_expected();
      bus.draw = 1'b1;
      repeat (100) tick();
      check("abort_addr", bus.sprite_addr, 64'h262);
      bus.draw = 1'b0;
      tick();
      check("abort_state", bus.draw_state, 64'(S_IDLE));
      check("abort_vga", bus.VGA_write, 64'd0);
      late_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         late_done = late_done | (bus.draw_done === 1'b1);
         tick();
      end
      check("abort_no_done", 64'(late_done), 64'd0);
      exp_q.delete();
      run_draw(518, 480);

      // Everyone dead: no pixels, 4 + 2 cycles
      for (int k = 0; k < 3; k++) apply_only(4'b1111, 4'b0011);
      alive_exp = 4'b0000;
      check("final_alive", bus.alive, 64'd0);
      check("final_all_dead", bus.all_dead, 64'd1);
      run_draw(6, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
